// File: rtl/capture_trigger_ctrl_if.sv
// capture_trigger_ctrl_if
//   Groups the control, sample-input and burst-output signals of
//   capture_trigger_ctrl into one bundle.
//   Signals keep the names of the original flat ports.
//   Inputs to the block:
//     iArm, iForce, iEdge, iThresh[DWID], iValid, iData[DWID]
//   Outputs from the block:
//     oTrig, oND, oData[DWID], oBusy, oDone, oPreCnt[$clog2(PRE_DEPTH)+1]
//   Modports:
//     master : drives the inputs and observes the outputs (source / bench side)
//     slave  : the capture block itself
interface capture_trigger_ctrl_if #(
   parameter int DWID      = 16,
   parameter int PRE_DEPTH = 8
);
   localparam int PCW = $clog2(PRE_DEPTH) + 1;

   logic            iArm;
   logic            iForce;
   logic            iEdge;
   logic [DWID-1:0] iThresh;
   logic            iValid;
   logic [DWID-1:0] iData;
   logic            oTrig;
   logic            oND;
   logic [DWID-1:0] oData;
   logic            oBusy;
   logic            oDone;
   logic [PCW-1:0]  oPreCnt;

   modport master (
      output iArm, iForce, iEdge, iThresh, iValid, iData,
      input  oTrig, oND, oData, oBusy, oDone, oPreCnt
   );

   modport slave (
      input  iArm, iForce, iEdge, iThresh, iValid, iData,
      output oTrig, oND, oData, oBusy, oDone, oPreCnt
   );
endinterface

// File: rtl/capture_trigger_ctrl.sv
// capture_trigger_ctrl
//   Pre/post-trigger capture stage feeding the text-file data writer.
//   Keeps a circular history of up to PRE_DEPTH samples while armed.
//   It detects a signed threshold crossing, or a forced trigger.
//   It then emits a one-cycle trigger pulse followed by a contiguous burst.
//   The burst holds the retained history first, then POST_LEN live samples.
//   The first live sample is the trigger sample itself.
//   Ports:
//     iClk   : clock, rising edge
//     iRst_n : asynchronous active-low reset
//     bus    : capture_trigger_ctrl_if.slave
//              inputs : iArm, iForce, iEdge, iThresh, iValid, iData
//              outputs: oTrig, oND, oData, oBusy, oDone, oPreCnt
//              all outputs are registered
module capture_trigger_ctrl #(
   parameter int DWID      = 16,
   parameter int PRE_DEPTH = 8,
   parameter int POST_LEN  = 64
) (
   input  logic                   iClk,
   input  logic                   iRst_n,
   capture_trigger_ctrl_if.slave  bus
);

   localparam int AW  = $clog2(2 * PRE_DEPTH);
   localparam int OCW = $clog2(PRE_DEPTH) + 2;
   localparam int PCW = $clog2(PRE_DEPTH) + 1;
   localparam int CW  = $clog2(POST_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_TRIG,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [DWID-1:0]        mem [2*PRE_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [OCW-1:0]         occ_q, occ_d;
   logic [CW-1:0]          post_cnt_q, post_cnt_d;
   logic signed [DWID-1:0] prev_q;
   logic                   prev_vld_q;

   logic                   oTrig_q, oND_q, oBusy_q, oDone_q;
   logic [DWID-1:0]        oData_q;
   logic [PCW-1:0]         oPreCnt_q;

   logic signed [DWID-1:0] cur, thr;
   logic                   rise_hit, fall_hit, trig_hit;
   logic                   wr_en, rd_en, drop;

   always_comb begin
      cur      = $signed(bus.iData);
      thr      = $signed(bus.iThresh);
      rise_hit = prev_vld_q && (prev_q < thr) && (cur >= thr);
      fall_hit = prev_vld_q && (prev_q > thr) && (cur <= thr);
      // iArm on the same cycle clears the history, so it also discards the sample.
      trig_hit = (state_q == S_ARMED) && !bus.iArm && bus.iValid &&
                 (bus.iForce || (bus.iEdge ? fall_hit : rise_hit));
      wr_en    = ((state_q == S_ARMED) && !bus.iArm && bus.iValid) ||
                 (((state_q == S_TRIG) || (state_q == S_STREAM)) && bus.iValid &&
                  (post_cnt_q < CW'(POST_LEN)));
      rd_en    = (state_q == S_STREAM) && (occ_q != '0);
      // A full history drops its oldest entry, except on the trigger write.
      drop     = (state_q == S_ARMED) && wr_en && !trig_hit &&
                 (occ_q == OCW'(PRE_DEPTH));

      occ_d = occ_q;
      if (wr_en && !(rd_en || drop))
         occ_d = occ_q + OCW'(1);
      else if (!wr_en && rd_en)
         occ_d = occ_q - OCW'(1);

      post_cnt_d = post_cnt_q;
      if (wr_en && ((state_q == S_TRIG) || (state_q == S_STREAM)))
         post_cnt_d = post_cnt_q + CW'(1);
   end

   // Sample storage is not reset; occupancy alone defines which words are live.
   always_ff @(posedge iClk) begin
      if (wr_en)
         mem[wr_ptr_q] <= bus.iData;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         post_cnt_q <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         oTrig_q    <= 1'b0;
         oND_q      <= 1'b0;
         oData_q    <= '0;
         oBusy_q    <= 1'b0;
         oDone_q    <= 1'b0;
         oPreCnt_q  <= '0;
      end else begin
         oTrig_q <= 1'b0;
         oND_q   <= 1'b0;
         occ_q   <= occ_d;
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en || drop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         if (rd_en) begin
            oND_q   <= 1'b1;
            oData_q <= mem[rd_ptr_q];
         end

         case (state_q)
            S_IDLE, S_DONE, S_ARMED: begin
               if (bus.iArm) begin
                  state_q    <= S_ARMED;
                  oBusy_q    <= 1'b1;
                  oDone_q    <= 1'b0;
                  wr_ptr_q   <= '0;
                  rd_ptr_q   <= '0;
                  occ_q      <= '0;
                  post_cnt_q <= '0;
                  prev_vld_q <= 1'b0;
                  oPreCnt_q  <= '0;
               end else if (state_q == S_ARMED && bus.iValid) begin
                  if (trig_hit) begin
                     state_q    <= S_TRIG;
                     oPreCnt_q  <= occ_q[PCW-1:0];
                     post_cnt_q <= CW'(1);
                  end else begin
                     prev_q     <= cur;
                     prev_vld_q <= 1'b1;
                  end
               end
            end
            S_TRIG: begin
               // The pulse becomes visible in the first STREAM cycle.
               // This places it directly ahead of the first oND.
               oTrig_q    <= 1'b1;
               post_cnt_q <= post_cnt_d;
               state_q    <= S_STREAM;
            end
            S_STREAM: begin
               post_cnt_q <= post_cnt_d;
               if (post_cnt_d == CW'(POST_LEN) && occ_d == '0) begin
                  state_q <= S_DONE;
                  oBusy_q <= 1'b0;
                  oDone_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.oTrig   = oTrig_q;
   assign bus.oND     = oND_q;
   assign bus.oData   = oData_q;
   assign bus.oBusy   = oBusy_q;
   assign bus.oDone   = oDone_q;
   assign bus.oPreCnt = oPreCnt_q;

endmodule
